// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader packing little-endian words into instruction memory
// Holds the core in reset until load_len words have been written; times out on a stalled source.
module imem_loader #(
  parameter int PC_SIZE        = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_start,
  input  logic [PC_SIZE-1:0] load_len,
  input  logic               load_abort,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [PC_SIZE-1:0] imem_addr,
  output logic [31:0]        imem_data,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t             state, state_n;
  logic [PC_SIZE-1:0] len_q, len_n;
  logic [PC_SIZE-1:0] word_idx, word_idx_n;
  logic [1:0]         byte_idx, byte_idx_n;
  logic [TW-1:0]      timer, timer_n;
  logic [31:0]        word_buf, word_buf_n;
  logic               ready_q;
  logic               xfer;

  // Abort must block a transfer in the very cycle it is raised.
  assign byte_ready = ready_q & ~load_abort;
  assign xfer       = byte_valid & byte_ready;

  always_comb begin
    state_n    = state;
    len_n      = len_q;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    timer_n    = timer;
    word_buf_n = word_buf;
    if (load_abort) begin
      state_n    = S_IDLE;
      byte_idx_n = 2'd0;
      timer_n    = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            len_n      = load_len;
            word_idx_n = '0;
            byte_idx_n = 2'd0;
            timer_n    = '0;
            state_n    = (load_len == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (xfer) begin
            word_buf_n[{byte_idx, 3'b000} +: 8] = byte_data;
            byte_idx_n = byte_idx + 2'd1;
            timer_n    = '0;
            if (byte_idx == 2'd3) state_n = S_WRITE;
          end else begin
            timer_n = timer + 1'b1;
            if (timer_n == TW'(TIMEOUT_CYCLES)) state_n = S_ERROR;
          end
        end
        S_WRITE: begin
          word_idx_n = word_idx + 1'b1;
          state_n    = (word_idx_n == len_q) ? S_DONE : S_RECV;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      timer      <= '0;
      word_buf   <= '0;
      ready_q    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_n;
      len_q      <= len_n;
      word_idx   <= word_idx_n;
      byte_idx   <= byte_idx_n;
      timer      <= timer_n;
      word_buf   <= word_buf_n;
      ready_q    <= (state_n == S_RECV);
      imem_we    <= (state_n == S_WRITE);
      core_reset <= (state_n != S_DONE);
      load_done  <= (state_n == S_DONE);
      load_error <= (state_n == S_ERROR);
      if (state_n == S_WRITE) begin
        imem_addr <= word_idx;
        imem_data <= word_buf_n;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
// Expected writes are queued from the byte program; a negedge monitor pops them on imem_we.
module tb_imem_loader;
  localparam int PCS = 10;
  localparam int TO  = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           load_start = 1'b0;
  logic [PCS-1:0] load_len = '0;
  logic           load_abort = 1'b0;
  logic           byte_valid = 1'b0;
  logic [7:0]     byte_data = 8'h00;
  logic           byte_ready, imem_we, core_reset, load_done, load_error;
  logic [PCS-1:0] imem_addr;
  logic [31:0]    imem_data;

  int checks = 0;
  int errors = 0;
  int writes = 0;

  typedef struct {
    logic [PCS-1:0] addr;
    logic [31:0]    data;
  } wr_t;
  wr_t        exp_q[$];
  logic [7:0] prog[$];

  imem_loader #(.PC_SIZE(PCS), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_len(load_len),
    .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .core_reset(core_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && imem_we) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_data, e.data);
        chk("ready_in_write", 32'(byte_ready), 32'd0);
      end
    end
  end

  // Reference: word w is bytes 4w..4w+3 with the first byte in the least significant lane.
  task automatic expect_words(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      wr_t e;
      e.addr = PCS'(w);
      e.data = 32'(prog[4*w]) + (32'(prog[4*w+1]) << 8) + (32'(prog[4*w+2]) << 16)
             + (32'(prog[4*w+3]) << 24);
      exp_q.push_back(e);
    end
  endtask

  task automatic random_prog(input int nbytes);
    prog.delete();
    for (int i = 0; i < nbytes; i++) prog.push_back(8'($urandom));
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = PCS'(len);
    @(posedge clock); #1;
    load_start = 1'b0;
    if (len == 0) begin
      chk("len0_done", 32'(load_done), 32'd1);
      chk("len0_core_reset", 32'(core_reset), 32'd0);
    end else begin
      chk("start_ready", 32'(byte_ready), 32'd1);
      chk("start_core_reset", 32'(core_reset), 32'd1);
      chk("start_clears", 32'({load_done, load_error}), 32'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clock); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = byte_ready;
      @(posedge clock); #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("load_done", 32'(load_done), 32'd1);
    chk("done_core_reset", 32'(core_reset), 32'd0);
  endtask

  task automatic full_load(input int len, input int maxgap, input bit poke_start);
    random_prog(len * 4);
    expect_words(len);
    start_load(len);
    for (int i = 0; i < len * 4; i++) begin
      if (poke_start && i == 2) begin
        load_start = 1'b1;
        load_len   = PCS'(5);
        @(posedge clock); #1;
        load_start = 1'b0;
      end
      send_byte(prog[i], $urandom_range(0, maxgap));
    end
    wait_done();
  endtask

  initial begin
    int idle;
    int w0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_outputs", {byte_ready, imem_we, core_reset, load_done, load_error}, 32'b00100);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    @(posedge clock); #1;

    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_words(2);
    chk("t1_ref_word1", exp_q[1].data, 32'h0010_0093);
    start_load(2);
    foreach (prog[i]) send_byte(prog[i], 0);
    @(negedge clock);
    chk("t1_we", 32'(imem_we), 32'd1);
    @(negedge clock);
    chk("t1_done_next", 32'(load_done), 32'd1);
    chk("t1_core_released", 32'(core_reset), 32'd0);

    w0 = writes;
    random_prog(4);
    expect_words(1);
    start_load(1);
    foreach (prog[i]) send_byte(prog[i], (i == 0) ? 0 : 1);
    wait_done();
    chk("t2_one_pulse", 32'(writes - w0), 32'd1);

    random_prog(8);
    start_load(2);
    send_byte(prog[0], 0);
    send_byte(prog[1], 0);
    idle = 0;
    while (idle < 40) begin
      @(negedge clock);
      if (load_error) break;
      idle++;
    end
    chk("t3_idle_cycles", 32'(idle), 32'(TO));
    chk("t3_error_outs", {core_reset, byte_ready, load_done}, 32'b100);
    @(posedge clock); #1;
    full_load(2, 3, 1'b0);
    chk("t3_error_cleared", 32'(load_error), 32'd0);

    w0 = writes;
    start_load(0);
    repeat (3) @(posedge clock);
    #1 chk("t4_no_writes", 32'(writes - w0), 32'd0);

    random_prog(8);
    expect_words(1);
    start_load(2);
    for (int i = 0; i < 7; i++) send_byte(prog[i], 0);
    byte_valid = 1'b1;
    byte_data  = prog[7];
    load_abort = 1'b1;
    @(negedge clock);
    chk("t5_abort_ready", 32'(byte_ready), 32'd0);
    @(posedge clock); #1;
    load_abort = 1'b0;
    chk("t5_idle_outs", {core_reset, byte_ready, load_done, load_error}, 32'b1000);
    repeat (4) @(posedge clock);
    #1 byte_valid = 1'b0;

    random_prog(12);
    expect_words(1);
    start_load(3);
    for (int i = 0; i < 5; i++) send_byte(prog[i], 0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_outputs", {byte_ready, imem_we, core_reset, load_done, load_error}, 32'b00100);
    chk("t6_rst_addr", 32'(imem_addr), 32'd0);
    chk("t6_rst_data", imem_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    full_load(3, 2, 1'b0);

    for (int r = 0; r < 6; r++) full_load($urandom_range(1, 6), 3, (r == 2));

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
